// File: rtl/axis_dac_slew_limit.sv
// Two-channel slew-rate limiter: each lane's output walks toward its captured target by at most step per clock.
// Optional macro AXIS_DAC_SLEW_HOLD_EN adds a 'hold' input that freezes both ramps while high.
module axis_dac_slew_limit #(
   parameter int ADC_WIDTH         = 14,
   parameter int MAXIS_DATA_WIDTH  = 16,
   parameter int MAXIS_TDATA_WIDTH = 32,
   parameter int STEP_WIDTH        = 14
) (
   input  logic                         a_clk,
   input  logic                         a_rst,
`ifdef AXIS_DAC_SLEW_HOLD_EN
   input  logic                         hold,
`endif
   input  logic [MAXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
   input  logic                         S_AXIS_tvalid,
   input  logic [STEP_WIDTH-1:0]        step_ch1,
   input  logic [STEP_WIDTH-1:0]        step_ch2,
   output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
   output logic                         M_AXIS_tvalid,
   output logic [1:0]                   limiting
);

   localparam int NCH = 2;
   localparam int DW  = ADC_WIDTH + 1;

   logic                  hold_w;
   logic [STEP_WIDTH-1:0] step_arr [NCH];
   logic                  seen_q, seen_d;
   logic                  valid_q, valid_d;

`ifdef AXIS_DAC_SLEW_HOLD_EN
   assign hold_w = hold;
`else
   assign hold_w = 1'b0;
`endif

   assign step_arr[0] = step_ch1;
   assign step_arr[1] = step_ch2;

   // Output valid follows the first capture by one edge so it lines up with the first updated sample.
   assign seen_d  = seen_q | S_AXIS_tvalid;
   assign valid_d = valid_q | seen_q;

   always_ff @(posedge a_clk or posedge a_rst) begin
      if (a_rst) begin
         seen_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         seen_q  <= seen_d;
         valid_q <= valid_d;
      end
   end

   assign M_AXIS_tvalid = valid_q;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [ADC_WIDTH-1:0] target_q, target_d;
         logic [ADC_WIDTH-1:0] current_q, current_d;
         logic                 lim_q, lim_d;
         logic [DW-1:0]        diff_w;
         logic [DW-1:0]        mag_w;
         logic [DW-1:0]        step_w;
         logic [ADC_WIDTH-1:0] up_w, dn_w;
         logic [ADC_WIDTH-1:0] lane_w;
         logic                 unused_lane_msbs;

         assign lane_w           = S_AXIS_tdata[gi*MAXIS_DATA_WIDTH +: ADC_WIDTH];
         assign unused_lane_msbs = ^S_AXIS_tdata[gi*MAXIS_DATA_WIDTH+ADC_WIDTH +: (MAXIS_DATA_WIDTH-ADC_WIDTH)];

         // One extra bit keeps target - current exact over the full 14-bit signed range.
         assign diff_w = {target_q[ADC_WIDTH-1], target_q} - {current_q[ADC_WIDTH-1], current_q};
         assign mag_w  = diff_w[DW-1] ? -diff_w : diff_w;
         assign step_w = DW'(step_arr[gi]);
         assign up_w   = current_q + step_w[ADC_WIDTH-1:0];
         assign dn_w   = current_q - step_w[ADC_WIDTH-1:0];

         assign target_d = S_AXIS_tvalid ? lane_w : target_q;

         always_comb begin
            current_d = current_q;
            lim_d     = lim_q;
            if (!hold_w) begin
               if ((step_w == '0) || (mag_w <= step_w)) begin
                  current_d = target_q;
                  lim_d     = 1'b0;
               end else if (diff_w[DW-1]) begin
                  current_d = dn_w;
                  lim_d     = 1'b1;
               end else begin
                  current_d = up_w;
                  lim_d     = 1'b1;
               end
            end
         end

         always_ff @(posedge a_clk or posedge a_rst) begin
            if (a_rst) begin
               target_q  <= '0;
               current_q <= '0;
               lim_q     <= 1'b0;
            end else begin
               target_q  <= target_d;
               current_q <= current_d;
               lim_q     <= lim_d;
            end
         end

         assign M_AXIS_tdata[gi*MAXIS_DATA_WIDTH +: MAXIS_DATA_WIDTH] =
            {{(MAXIS_DATA_WIDTH-ADC_WIDTH){current_q[ADC_WIDTH-1]}}, current_q};
         assign limiting[gi] = lim_q;
      end
   endgenerate

endmodule

// File: tb/tb_axis_dac_slew_limit.sv
// Self-checking bench for axis_dac_slew_limit: directed scenarios plus randomized traffic against a behavioural model.
module tb_axis_dac_slew_limit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hold = 1'b0;
   logic [31:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic [13:0] step_ch1 = '0;
   logic [13:0] step_ch2 = '0;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic [1:0]  limiting;

   int n_checks = 0;
   int n_pass   = 0;

   // behavioural model state
   int m_tgt [2];
   int m_cur [2];
   bit m_lim [2];
   bit m_seen;
   bit m_valid;

   always #5 clk = ~clk;

   axis_dac_slew_limit dut (
      .a_clk        (clk),
      .a_rst        (rst),
`ifdef AXIS_DAC_SLEW_HOLD_EN
      .hold         (hold),
`endif
      .S_AXIS_tdata (s_tdata),
      .S_AXIS_tvalid(s_tvalid),
      .step_ch1     (step_ch1),
      .step_ch2     (step_ch2),
      .M_AXIS_tdata (m_tdata),
      .M_AXIS_tvalid(m_tvalid),
      .limiting     (limiting)
   );

   task automatic model_reset();
      for (int ch = 0; ch < 2; ch++) begin
         m_tgt[ch] = 0;
         m_cur[ch] = 0;
         m_lim[ch] = 0;
      end
      m_seen  = 0;
      m_valid = 0;
   endtask

   // Advance the model with the inputs present before the edge, then let the edge happen.
   task automatic tick();
      logic signed [13:0] lane;
      int d, s, mag;
      for (int ch = 0; ch < 2; ch++) begin
         s   = (ch == 0) ? int'(step_ch1) : int'(step_ch2);
         d   = m_tgt[ch] - m_cur[ch];
         mag = (d < 0) ? -d : d;
         if (!hold) begin
            if (s == 0 || mag <= s) begin
               m_cur[ch] = m_tgt[ch];
               m_lim[ch] = 0;
            end else begin
               m_cur[ch] = m_cur[ch] + ((d > 0) ? s : -s);
               m_lim[ch] = 1;
            end
         end
      end
      if (s_tvalid) begin
         for (int ch = 0; ch < 2; ch++) begin
            lane = s_tdata[ch*16 +: 14];
            m_tgt[ch] = int'(lane);
         end
      end
      m_valid = m_valid | m_seen;
      m_seen  = m_seen | s_tvalid;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [34:0] model_word();
      logic [15:0] l0, l1;
      l0 = 16'(m_cur[0]);
      l1 = 16'(m_cur[1]);
      return {l1, l0, m_valid, m_lim[1], m_lim[0]};
   endfunction

   task automatic capture(input logic [31:0] data);
      s_tdata  = data;
      s_tvalid = 1'b1;
      tick();
      s_tvalid = 1'b0;
   endtask

   // Drive both targets to zero with unlimited step and let them land.
   task automatic settle_zero();
      step_ch1 = '0;
      step_ch2 = '0;
      capture(32'h0000_0000);
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      #2;
      n_checks++;
      if ({m_tdata, m_tvalid, limiting} !== 35'h0)
         $display("FAIL reset_state got tdata=%h valid=%b lim=%b want all zero", m_tdata, m_tvalid, limiting);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({m_tdata, m_tvalid, limiting} !== 35'h0)
            $display("FAIL reset_idle cyc %0d got tdata=%h valid=%b lim=%b want all zero", i, m_tdata, m_tvalid, limiting);
         else n_pass++;
      end
      $display("test_reset done");
   endtask

   task automatic test_passthrough();
      step_ch1 = '0;
      step_ch2 = '0;
      capture(32'h2000_1FFF);
      n_checks++;
      if ({m_tdata, m_tvalid} !== {32'h0, 1'b0})
         $display("FAIL pass_latency got tdata=%h valid=%b want 00000000/0", m_tdata, m_tvalid);
      else n_pass++;
      tick();
      n_checks++;
      if ({m_tdata, m_tvalid, limiting} !== {32'hE000_1FFF, 1'b1, 2'b00})
         $display("FAIL pass_clean got tdata=%h valid=%b lim=%b want E0001FFF/1/00", m_tdata, m_tvalid, limiting);
      else n_pass++;
      settle_zero();
      // bits [15:14] of each lane are garbage and must be ignored
      capture(32'hE000_9FFF);
      tick();
      n_checks++;
      if ({m_tdata, m_tvalid, limiting} !== {32'hE000_1FFF, 1'b1, 2'b00})
         $display("FAIL pass_garbage got tdata=%h valid=%b lim=%b want E0001FFF/1/00", m_tdata, m_tvalid, limiting);
      else n_pass++;
      $display("test_passthrough done");
   endtask

   task automatic test_ramp();
      logic [15:0] want;
      settle_zero();
      step_ch1 = 14'd100;
      step_ch2 = '0;
      capture(32'h0000_03E8);
      for (int i = 1; i <= 10; i++) begin
         tick();
         want = 16'(100 * i);
         n_checks++;
         if ({m_tdata, limiting} !== {16'h0000, want, 1'b0, (i < 10)})
            $display("FAIL ramp step %0d got tdata=%h lim=%b want %h/%b", i, m_tdata, limiting, {16'h0000, want}, {1'b0, (i < 10)});
         else n_pass++;
      end
      $display("test_ramp done");
   endtask

   task automatic test_full_scale();
      logic [34:0] want [3];
      want[0] = {32'h0000_FFFF, 1'b1, 2'b11};
      want[1] = {32'hE001_1FFE, 1'b1, 2'b11};
      want[2] = {32'hE000_1FFF, 1'b1, 2'b00};
      step_ch1 = '0;
      step_ch2 = '0;
      capture(32'h1FFF_2000);
      tick();
      step_ch1 = 14'd8191;
      step_ch2 = 14'd8191;
      capture(32'h2000_1FFF);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({m_tdata, m_tvalid, limiting} !== want[i])
            $display("FAIL full_step8191 edge %0d got %h/%b/%b want %h", i, m_tdata, m_tvalid, limiting, want[i]);
         else n_pass++;
      end
      step_ch1 = 14'd16383;
      step_ch2 = 14'd16383;
      capture(32'h1FFF_2000);
      tick();
      n_checks++;
      if ({m_tdata, m_tvalid, limiting} !== {32'h1FFF_E000, 1'b1, 2'b00})
         $display("FAIL full_step16383 got %h/%b/%b want 1FFFE000/1/00", m_tdata, m_tvalid, limiting);
      else n_pass++;
      $display("test_full_scale done");
   endtask

   task automatic test_redirect_reset();
      logic [15:0] want;
      settle_zero();
      step_ch1 = 14'd100;
      capture(32'h0000_03E8);
      for (int i = 0; i < 4; i++) tick();
      capture(32'h0000_3F38);   // -200 in 14 bits, lands on the edge that reaches 500
      n_checks++;
      if (m_tdata[15:0] !== 16'd500)
         $display("FAIL redirect_at500 got %h want 01F4", m_tdata[15:0]);
      else n_pass++;
      for (int i = 1; i <= 7; i++) begin
         tick();
         want = 16'(500 - 100 * i);
         n_checks++;
         if ({m_tdata[15:0], limiting[0]} !== {want, (i < 7)})
            $display("FAIL redirect step %0d got %h/%b want %h/%b", i, m_tdata[15:0], limiting[0], want, (i < 7));
         else n_pass++;
      end
      settle_zero();
      step_ch1 = 14'd100;
      capture(32'h0000_03E8);
      for (int i = 0; i < 3; i++) tick();
      n_checks++;
      if (m_tdata[15:0] !== 16'd300)
         $display("FAIL reset_ramp_pre got %h want 012C", m_tdata[15:0]);
      else n_pass++;
      #3 rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if ({m_tdata, m_tvalid, limiting} !== 35'h0)
         $display("FAIL async_reset got %h/%b/%b want all zero", m_tdata, m_tvalid, limiting);
      else n_pass++;
      #1 rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if ({m_tdata, m_tvalid, limiting} !== 35'h0)
            $display("FAIL post_reset cyc %0d got %h/%b/%b want all zero", i, m_tdata, m_tvalid, limiting);
         else n_pass++;
      end
      $display("test_redirect_reset done");
   endtask

`ifdef AXIS_DAC_SLEW_HOLD_EN
   task automatic test_hold();
      settle_zero();
      step_ch1 = 14'd100;
      capture(32'h0000_03E8);
      for (int i = 0; i < 3; i++) tick();
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if ({m_tdata[15:0], limiting[0]} !== {16'd300, 1'b1})
            $display("FAIL hold cyc %0d got %h/%b want 012C/1", i, m_tdata[15:0], limiting[0]);
         else n_pass++;
      end
      hold = 1'b0;
      tick();
      n_checks++;
      if (m_tdata[15:0] !== 16'd400)
         $display("FAIL hold_release got %h want 0190", m_tdata[15:0]);
      else n_pass++;
      $display("test_hold done");
   endtask
`endif

   task automatic test_random();
      logic [34:0] want;
      for (int i = 0; i < 400; i++) begin
         s_tvalid = ($urandom_range(0, 7) == 0);
         s_tdata  = $urandom;
         case ($urandom_range(0, 9))
            0:       step_ch1 = '0;
            1:       step_ch1 = 14'($urandom_range(1000, 16383));
            default: step_ch1 = 14'($urandom_range(1, 400));
         endcase
         case ($urandom_range(0, 9))
            0:       step_ch2 = '0;
            1:       step_ch2 = 14'($urandom_range(1000, 16383));
            default: step_ch2 = 14'($urandom_range(1, 400));
         endcase
         tick();
         want = model_word();
         n_checks++;
         if ({m_tdata, m_tvalid, limiting} !== want)
            $display("FAIL random cyc %0d got %h/%b/%b want %h/%b/%b", i, m_tdata, m_tvalid, limiting,
                     want[34:3], want[2], want[1:0]);
         else n_pass++;
      end
      s_tvalid = 1'b0;
      $display("test_random done");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_passthrough();
      test_ramp();
      test_full_scale();
      test_redirect_reset();
`ifdef AXIS_DAC_SLEW_HOLD_EN
      test_hold();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
